axil_ptgen_master: RTL
======================

// Module: axil_ptgen_master
// PURPOSE
// Parametrised AXI4-Lite master pattern-test engine for the jpeg_preprocess IP. On an INIT pulse it
// writes N words of a selectable pattern from BASE_ADDR, reads them back and compares, then reports
// DONE, ERROR, an error count and the first failing address. Replaces the fixed incrementing M00_AXI master.
// PARAMETERS
// ADDR_WIDTH    32            AXI address width
// DATA_WIDTH    32            AXI data width (32 or 64); stride = DATA_WIDTH/8 bytes
// MAX_TXN       64            max words per run; CFG_NUM_TXN width = $clog2(MAX_TXN+1)
// BASE_ADDR     'h4000_0000   address of word 0
// LFSR_POLY     'h8020_0003   Galois LFSR taps (low DATA_WIDTH bits used)
// PORTS
// ACLK            in   1           clock
// ARESETN         in   1           synchronous active-low reset
// INIT_AXI_TXN    in   1           start request; rising edge sampled
// CFG_NUM_TXN     in   CW          words per run, latched at start
// CFG_MODE        in   2           0 incr, 1 walking-one, 2 LFSR, 3 constant; latched at start
// CFG_SEED        in   DATA_WIDTH  pattern seed, latched at start
// TXN_DONE        out  1           run complete; held until next accepted start
// ERROR           out  1           sticky: mismatch or non-OKAY resp in current/last run
// ERR_COUNT       out  CW          mismatching/failed reads, saturating at MAX_TXN
// FIRST_ERR_ADDR  out  ADDR_WIDTH  address of first failure in run
// BUSY            out  1           high from start until TXN_DONE
// M_AXI_AW{ADDR,PROT,VALID,READY}  AW channel (PROT=3'b000)
// M_AXI_W{DATA,STRB,VALID,READY}   W channel (STRB all ones)
// M_AXI_B{RESP,VALID,READY}        B channel
// M_AXI_AR{ADDR,PROT,VALID,READY}  AR channel (PROT=3'b000)
// M_AXI_R{DATA,RESP,VALID,READY}   R channel
// BEHAVIOUR
// - Reset (ARESETN=0 at ACLK edge): all VALID/READY outputs 0, TXN_DONE/ERROR/BUSY 0, ERR_COUNT 0,
//   FIRST_ERR_ADDR 0, FSM IDLE. Reset mid-run aborts immediately; no further beats issued.
// - FSM: IDLE -> WR_ISSUE -> WR_RESP -> (loop) -> RD_ISSUE -> RD_DATA -> (loop) -> DONE.
// - Start: INIT rising edge (registered delay) while not BUSY; edge during BUSY ignored. Start latches
//   CFG_*, clears TXN_DONE/ERROR/ERR_COUNT/FIRST_ERR_ADDR, sets BUSY, index i=0. DONE -> start allowed.
// - CFG_NUM_TXN=0: straight to DONE next cycle, no AXI traffic, ERROR=0. Values >MAX_TXN clamp to MAX_TXN.
// - One outstanding transaction. WR_ISSUE: AWVALID and WVALID rise together, each drops the cycle after
//   its own READY handshake (either order, or same cycle). WR_RESP: BREADY=1; BVALID accepted ->
//   BRESP!=OKAY sets ERROR, counts, records addr if first; i++; i==N -> RD_ISSUE with i=0.
// - RD_ISSUE: ARVALID until ARREADY. RD_DATA: RREADY=1; on RVALID compare RDATA to pattern(i);
//   mismatch or RRESP!=OKAY -> ERROR=1, ERR_COUNT+1 (saturate), FIRST_ERR_ADDR if first. One count per beat max.
// - VALID never drops before READY; ADDR/DATA stable while VALID. Min 1 idle cycle between transactions.
// - Address(i) = BASE_ADDR + i*DATA_WIDTH/8, modulo 2^ADDR_WIDTH (wraps silently).
// - Pattern(i): incr = SEED+i (mod 2^DW); walking-one = 1<<((i + SEED[5:0]) mod DW);
//   LFSR = SEED advanced i steps (Galois shift right, XOR LFSR_POLY when LSB=1; SEED=0 -> use 1);
//   constant = SEED. Read phase regenerates from latched seed, not stored data.
// - DONE: TXN_DONE=1, BUSY=0; outputs hold until next start or reset.
// - Latency: first AWVALID 2 cycles after INIT edge; zero-wait slave: 3 cycles per write, 3 per read.
// STRUCTURE
// - Package axil_ptgen_pkg: pattern_mode_e enum, ptgen_state_e enum, AXI_RESP_OKAY constant,
//   function lfsr_step(). Shared with the bench for expected-data generation.
// - Sub-module axil_ptgen_pattern: seed/mode in, restart + advance strobes, DATA_WIDTH word out
//   (one step per advance, restart reloads seed). FSM/channel logic stays in top.
// TESTING
// - Incr, N=4, SEED=1, memory slave: writes 1,2,3,4 to BASE+0..0xC, reads match -> DONE=1, ERROR=0, ERR_COUNT=0.
// - LFSR, N=16, SEED='hACE1, slave forces word 5 RDATA^=1 -> ERROR=1, ERR_COUNT=1, FIRST_ERR_ADDR=BASE+0x14.
// - Walking-one N=33 DW=32 SEED=0: word 32 = 'h1; slave BRESP=SLVERR on word 2 -> ERROR=1, run completes, DONE=1.
// - Random ready/valid delays (0-7 cycles, AWREADY before/after WREADY) N=64 -> no protocol violation, ERROR=0.
// - N=0 -> DONE 1 cycle after start, no AW/AR beats; INIT pulse while BUSY -> ignored, count unchanged.
// - ARESETN low during word 3 write -> next edge all VALIDs 0, outputs reset; new INIT -> clean run passes.

Source files
------------

// File: rtl/axil_ptgen_pkg.sv
// Shared definitions for the AXI4-Lite pattern-test master.
// Contents: pattern mode and FSM state enums, the OKAY response code and
// the Galois LFSR step used by both the pattern generator and the bench.
package axil_ptgen_pkg;

  typedef enum logic [1:0] {
    PAT_INCR  = 2'd0,
    PAT_WALK  = 2'd1,
    PAT_LFSR  = 2'd2,
    PAT_CONST = 2'd3
  } pattern_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_ISSUE = 3'd1,
    ST_WR_RESP  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_DATA  = 3'd4,
    ST_DONE     = 3'd5
  } ptgen_state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // One Galois step on the low 'width' bits: shift right, fold taps in when
  // the bit shifted out was 1. Bits above 'width' are always returned as 0.
  function automatic logic [63:0] lfsr_step(input logic [63:0] state,
                                            input logic [63:0] poly,
                                            input int unsigned width);
    logic [63:0] mask;
    logic [63:0] nxt;
    if (width >= 64) begin
      mask = {64{1'b1}};
    end else begin
      mask = (64'd1 << width) - 64'd1;
    end
    nxt = (state & mask) >> 1;
    if (state[0]) begin
      nxt = nxt ^ (poly & mask);
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/axil_ptgen_pattern.sv
// Pattern word generator.
// Ports: clk, rst_n (sync active-low), mode/seed (pattern selection),
// restart (reload word 0 from seed), advance (step to next word),
// word (current pattern word, valid the cycle after restart/advance).
module axil_ptgen_pattern
  import axil_ptgen_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter logic [63:0] LFSR_POLY  = 64'h8020_0003
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  restart,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] word
);

  localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] word_r;
  logic [DATA_WIDTH-1:0] init_s;
  logic [DATA_WIDTH-1:0] next_s;

  // Word 0 and the successor of the current word for each mode.
  // Walking-one advances by rotation so the bit position wraps modulo DW.
  always_comb begin
    init_s = seed;
    next_s = word_r;
    case (pattern_mode_e'(mode))
      PAT_INCR: begin
        init_s = seed;
        next_s = word_r + ONE;
      end
      PAT_WALK: begin
        init_s = ONE << (int'(seed[5:0]) % DATA_WIDTH);
        next_s = {word_r[DATA_WIDTH-2:0], word_r[DATA_WIDTH-1]};
      end
      PAT_LFSR: begin
        init_s = (seed == ZERO) ? ONE : seed;
        next_s = DATA_WIDTH'(lfsr_step(64'(word_r), LFSR_POLY, DATA_WIDTH));
      end
      PAT_CONST: begin
        init_s = seed;
        next_s = word_r;
      end
      default: begin
        init_s = seed;
        next_s = word_r;
      end
    endcase
  end

  // Current pattern word register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_r <= ZERO;
    end else if (restart) begin
      word_r <= init_s;
    end else if (advance) begin
      word_r <= next_s;
    end
  end

  assign word = word_r;

endmodule

// File: rtl/axil_ptgen_master.sv
// AXI4-Lite pattern-test master: on an INIT rising edge writes N pattern
// words from BASE_ADDR, reads them back and compares.
// Ports: ACLK/ARESETN (sync active-low), INIT_AXI_TXN start request,
// CFG_NUM_TXN/CFG_MODE/CFG_SEED run config (latched at start),
// TXN_DONE/ERROR/ERR_COUNT/FIRST_ERR_ADDR/BUSY status, M_AXI_* master port.
module axil_ptgen_master
  import axil_ptgen_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MAX_TXN    = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h4000_0000,
  parameter logic [63:0]           LFSR_POLY  = 64'h8020_0003
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          INIT_AXI_TXN,
  input  logic [$clog2(MAX_TXN+1)-1:0]  CFG_NUM_TXN,
  input  logic [1:0]                    CFG_MODE,
  input  logic [DATA_WIDTH-1:0]         CFG_SEED,
  output logic                          TXN_DONE,
  output logic                          ERROR,
  output logic [$clog2(MAX_TXN+1)-1:0]  ERR_COUNT,
  output logic [ADDR_WIDTH-1:0]         FIRST_ERR_ADDR,
  output logic                          BUSY,
  output logic [ADDR_WIDTH-1:0]         M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]         M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]       M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]         M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int                    CW      = $clog2(MAX_TXN+1);
  localparam logic [CW-1:0]         MAX_N   = CW'(MAX_TXN);
  localparam logic [ADDR_WIDTH-1:0] STRIDE  = ADDR_WIDTH'(DATA_WIDTH/8);

  ptgen_state_e          state_r, state_nxt_s;
  logic                  init_ff1_r, init_ff2_r;
  logic [CW-1:0]         num_r, idx_r, err_count_r, num_clamp_s;
  logic [1:0]            mode_r;
  logic [DATA_WIDTH-1:0] seed_r;
  logic [ADDR_WIDTH-1:0] addr_r, first_err_addr_r;
  logic                  aw_done_r, w_done_r, gap_r, error_r;
  logic                  awvalid_s, wvalid_s, arvalid_s, bready_s, rready_s;
  logic                  busy_s, done_s;
  logic                  start_s, aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic                  wr_both_s, last_s, fail_s;
  logic                  pat_restart_s, pat_advance_s;
  logic [1:0]            pat_mode_s;
  logic [DATA_WIDTH-1:0] pat_seed_s, pat_word_s;

  // Start is the registered rising edge of INIT, accepted only when idle/done.
  assign start_s     = init_ff1_r & ~init_ff2_r & ((state_r == ST_IDLE) | (state_r == ST_DONE));
  assign num_clamp_s = (CFG_NUM_TXN > MAX_N) ? MAX_N : CFG_NUM_TXN;
  assign aw_hs_s     = awvalid_s & M_AXI_AWREADY;
  assign w_hs_s      = wvalid_s & M_AXI_WREADY;
  assign b_hs_s      = bready_s & M_AXI_BVALID;
  assign ar_hs_s     = arvalid_s & M_AXI_ARREADY;
  assign r_hs_s      = rready_s & M_AXI_RVALID;
  assign wr_both_s   = (aw_done_r | aw_hs_s) & (w_done_r | w_hs_s);
  assign last_s      = (idx_r == (num_r - CW'(1)));
  assign fail_s      = (b_hs_s & (M_AXI_BRESP != AXI_RESP_OKAY)) |
                       (r_hs_s & ((M_AXI_RDATA != pat_word_s) | (M_AXI_RRESP != AXI_RESP_OKAY)));

  // The generator restarts from the live config at start (latched copies are
  // not loaded yet), and from the latched copy when the read phase begins.
  assign pat_restart_s = start_s | (b_hs_s & last_s);
  assign pat_advance_s = (b_hs_s | r_hs_s) & ~last_s;
  assign pat_mode_s    = start_s ? CFG_MODE : mode_r;
  assign pat_seed_s    = start_s ? CFG_SEED : seed_r;

  axil_ptgen_pattern #(
    .DATA_WIDTH (DATA_WIDTH),
    .LFSR_POLY  (LFSR_POLY)
  ) u_pattern (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .mode    (pat_mode_s),
    .seed    (pat_seed_s),
    .restart (pat_restart_s),
    .advance (pat_advance_s),
    .word    (pat_word_s)
  );

  // FSM state register.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_s) begin
          state_nxt_s = (num_clamp_s == {CW{1'b0}}) ? ST_DONE : ST_WR_ISSUE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_WR_ISSUE: begin
        if (wr_both_s) state_nxt_s = ST_WR_RESP;
        else           state_nxt_s = ST_WR_ISSUE;
      end
      ST_WR_RESP: begin
        if (b_hs_s) state_nxt_s = last_s ? ST_RD_ISSUE : ST_WR_ISSUE;
        else        state_nxt_s = ST_WR_RESP;
      end
      ST_RD_ISSUE: begin
        if (ar_hs_s) state_nxt_s = ST_RD_DATA;
        else         state_nxt_s = ST_RD_ISSUE;
      end
      ST_RD_DATA: begin
        if (r_hs_s) state_nxt_s = last_s ? ST_DONE : ST_RD_ISSUE;
        else        state_nxt_s = ST_RD_DATA;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode; gap_r holds VALIDs low for one cycle after each response.
  always_comb begin
    awvalid_s = 1'b0;
    wvalid_s  = 1'b0;
    arvalid_s = 1'b0;
    bready_s  = 1'b0;
    rready_s  = 1'b0;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_WR_ISSUE: begin
        awvalid_s = ~gap_r & ~aw_done_r;
        wvalid_s  = ~gap_r & ~w_done_r;
        busy_s    = 1'b1;
      end
      ST_WR_RESP: begin
        bready_s = 1'b1;
        busy_s   = 1'b1;
      end
      ST_RD_ISSUE: begin
        arvalid_s = ~gap_r;
        busy_s    = 1'b1;
      end
      ST_RD_DATA: begin
        rready_s = 1'b1;
        busy_s   = 1'b1;
      end
      ST_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Run datapath: config latch, word index/address, handshake flags, error status.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      init_ff1_r       <= 1'b0;
      init_ff2_r       <= 1'b0;
      gap_r            <= 1'b0;
      num_r            <= {CW{1'b0}};
      mode_r           <= 2'b00;
      seed_r           <= {DATA_WIDTH{1'b0}};
      idx_r            <= {CW{1'b0}};
      addr_r           <= {ADDR_WIDTH{1'b0}};
      aw_done_r        <= 1'b0;
      w_done_r         <= 1'b0;
      error_r          <= 1'b0;
      err_count_r      <= {CW{1'b0}};
      first_err_addr_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      init_ff1_r <= INIT_AXI_TXN;
      init_ff2_r <= init_ff1_r;
      gap_r      <= b_hs_s | r_hs_s;
      if (start_s) begin
        num_r            <= num_clamp_s;
        mode_r           <= CFG_MODE;
        seed_r           <= CFG_SEED;
        idx_r            <= {CW{1'b0}};
        addr_r           <= BASE_ADDR;
        aw_done_r        <= 1'b0;
        w_done_r         <= 1'b0;
        error_r          <= 1'b0;
        err_count_r      <= {CW{1'b0}};
        first_err_addr_r <= {ADDR_WIDTH{1'b0}};
      end else begin
        if (wr_both_s) begin
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
        end else begin
          if (aw_hs_s) aw_done_r <= 1'b1;
          if (w_hs_s)  w_done_r  <= 1'b1;
        end
        if (b_hs_s | r_hs_s) begin
          if (last_s) begin
            idx_r  <= {CW{1'b0}};
            addr_r <= BASE_ADDR;
          end else begin
            idx_r  <= idx_r + CW'(1);
            addr_r <= addr_r + STRIDE;
          end
        end
        if (fail_s) begin
          error_r <= 1'b1;
          if (err_count_r < MAX_N) err_count_r <= err_count_r + CW'(1);
          if (!error_r) first_err_addr_r <= addr_r;
        end
      end
    end
  end

  assign TXN_DONE       = done_s;
  assign BUSY           = busy_s;
  assign ERROR          = error_r;
  assign ERR_COUNT      = err_count_r;
  assign FIRST_ERR_ADDR = first_err_addr_r;
  assign M_AXI_AWADDR   = addr_r;
  assign M_AXI_AWPROT   = 3'b000;
  assign M_AXI_AWVALID  = awvalid_s;
  assign M_AXI_WDATA    = pat_word_s;
  assign M_AXI_WSTRB    = {(DATA_WIDTH/8){1'b1}};
  assign M_AXI_WVALID   = wvalid_s;
  assign M_AXI_BREADY   = bready_s;
  assign M_AXI_ARADDR   = addr_r;
  assign M_AXI_ARPROT   = 3'b000;
  assign M_AXI_ARVALID  = arvalid_s;
  assign M_AXI_RREADY   = rready_s;

endmodule
